// File: rtl/trap_ctrl_pkg.sv
// Shared constants, state encoding and CSR update helpers for the trap sequencer.
package trap_ctrl_pkg;

  // Exception op codes from the execute stage
  localparam logic [3:0] C_EXCEPTOP_NONE    = 4'd0;
  localparam logic [3:0] C_EXCEPTOP_ECALL   = 4'd1;
  localparam logic [3:0] C_EXCEPTOP_EBREAK  = 4'd2;
  localparam logic [3:0] C_EXCEPTOP_ILLEGAL = 4'd3;

  // Machine-mode CSR addresses
  localparam logic [11:0] CSR_ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_ADDR_MIE     = 12'h304;
  localparam logic [11:0] CSR_ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_ADDR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_ADDR_MTVAL   = 12'h343;

  // Synchronous exception cause codes
  localparam logic [31:0] EXCEPT_CODE_ECALL_M      = 32'd11;
  localparam logic [31:0] EXCEPT_CODE_BREAKPOINT   = 32'd3;
  localparam logic [31:0] EXCEPT_CODE_ILLEGAL_INSN = 32'd2;

  // Interrupt cause codes (low bits of mcause, interrupt flag in bit 31)
  localparam logic [3:0] IRQ_CODE_MSI = 4'd3;
  localparam logic [3:0] IRQ_CODE_MTI = 4'd7;
  localparam logic [3:0] IRQ_CODE_MEI = 4'd11;

  // mstatus field positions
  localparam int unsigned MSTATUS_MIE  = 3;
  localparam int unsigned MSTATUS_MPIE = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_W_MEPC,
    ST_W_MCAUSE,
    ST_W_MTVAL,
    ST_W_MSTATUS,
    ST_R_MSTATUS,
    ST_REDIRECT
  } state_t;

  function automatic logic [31:0] except_cause(input logic [3:0] op);
    logic [31:0] c;
    c = '0;
    case (op)
      C_EXCEPTOP_ECALL:   c = EXCEPT_CODE_ECALL_M;
      C_EXCEPTOP_EBREAK:  c = EXCEPT_CODE_BREAKPOINT;
      C_EXCEPTOP_ILLEGAL: c = EXCEPT_CODE_ILLEGAL_INSN;
      default:            c = '0;
    endcase
    return c;
  endfunction

  // Trap entry: stash MIE in MPIE, disable interrupts, previous mode = M
  function automatic logic [31:0] trap_mstatus(input logic [31:0] m);
    logic [31:0] r;
    r               = m;
    r[MSTATUS_MPIE] = m[MSTATUS_MIE];
    r[MSTATUS_MIE]  = 1'b0;
    r[12:11]        = 2'b11;
    return r;
  endfunction

  // Trap return: restore MIE from MPIE, set MPIE, previous mode = M
  function automatic logic [31:0] mret_mstatus(input logic [31:0] m);
    logic [31:0] r;
    r               = m;
    r[MSTATUS_MIE]  = m[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    r[12:11]        = 2'b11;
    return r;
  endfunction

endpackage

// File: rtl/trap_ctrl_irq_arbiter.sv
// Fixed-priority interrupt selector: external > software > timer, gated by the
// global MIE bit and the per-source mie enables.
module trap_ctrl_irq_arbiter
  import trap_ctrl_pkg::*;
(
  input  logic        irq_ext,
  input  logic        irq_sw,
  input  logic        irq_timer,
  input  logic        global_en,
  input  logic [31:0] mie,
  output logic        irq_valid,
  output logic [3:0]  irq_code
);

  logic unused_mie;
  assign unused_mie = ^{mie[31:12], mie[10:8], mie[6:4], mie[2:0]};

  // Pick the highest-priority enabled pending source
  always_comb begin
    irq_valid = 1'b0;
    irq_code  = '0;
    if (global_en) begin
      if (irq_ext && mie[11]) begin
        irq_valid = 1'b1;
        irq_code  = IRQ_CODE_MEI;
      end else if (irq_sw && mie[3]) begin
        irq_valid = 1'b1;
        irq_code  = IRQ_CODE_MSI;
      end else if (irq_timer && mie[7]) begin
        irq_valid = 1'b1;
        irq_code  = IRQ_CODE_MTI;
      end
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: accepts one exception/interrupt/MRET event,
// streams its CSR writes over the single write port, then redirects fetch.
// Optional TRAP_CTRL_VECTORED_EN: vectored interrupt targets when mtvec[1:0]==01.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        except_en,
  input  logic [3:0]  except_op,
  input  logic [31:0] except_pc,
  input  logic [31:0] except_tval,
  input  logic        mret_en,
  input  logic [31:0] next_pc,
  input  logic        irq_ext,
  input  logic        irq_sw,
  input  logic        irq_timer,
  input  logic [31:0] mstatus,
  input  logic [31:0] mie,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  output logic        csr_wr_en,
  output logic [11:0] csr_wr_addr,
  output logic [31:0] csr_wr_data,
  output logic        flush,
  output logic        busy,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  state_t      state;
  logic [31:0] cause_q;
  logic [31:0] tval_q;

  logic        irq_valid;
  logic [3:0]  irq_code;
  logic        take_trap;
  logic        take_mret;
  logic [31:0] ev_epc;
  logic [31:0] ev_cause;
  logic [31:0] ev_tval;
  logic [31:0] trap_base;
  logic [31:0] trap_target;

  trap_ctrl_irq_arbiter u_irq_arbiter (
    .irq_ext   (irq_ext),
    .irq_sw    (irq_sw),
    .irq_timer (irq_timer),
    .global_en (mstatus[MSTATUS_MIE]),
    .mie       (mie),
    .irq_valid (irq_valid),
    .irq_code  (irq_code)
  );

  // Event acceptance and the values captured with it
  always_comb begin
    take_trap = 1'b0;
    take_mret = 1'b0;
    ev_epc    = next_pc;
    ev_cause  = {1'b1, 27'b0, irq_code};
    ev_tval   = '0;
    if (except_en) begin
      ev_epc   = except_pc;
      ev_cause = except_cause(except_op);
      ev_tval  = except_tval;
    end
    if (state == ST_IDLE && !stall && !reset) begin
      if (except_en || irq_valid) begin
        take_trap = 1'b1;
      end else if (mret_en) begin
        take_mret = 1'b1;
      end
    end
  end

  // Trap vector; the captured cause tells interrupts apart for vectored mode
  always_comb begin
    trap_base = mtvec & ~32'h3;
    if (trap_base == '0) begin
      trap_base = RESET_VECTOR;
    end
    trap_target = trap_base;
`ifdef TRAP_CTRL_VECTORED_EN
    if (mtvec[1:0] == 2'b01 && cause_q[31]) begin
      trap_target = trap_base + {26'b0, cause_q[3:0], 2'b00};
    end
`endif
  end

  assign flush = take_trap | take_mret;
  assign busy  = (state != ST_IDLE);

  // Sequencer; outputs are registered alongside the state they belong to,
  // so a stalled cycle simply keeps every output where it was.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      cause_q        <= '0;
      tval_q         <= '0;
      csr_wr_en      <= 1'b0;
      csr_wr_addr    <= '0;
      csr_wr_data    <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else if (!stall) begin
      csr_wr_en      <= 1'b0;
      csr_wr_addr    <= '0;
      csr_wr_data    <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      case (state)
        ST_IDLE: begin
          if (take_trap) begin
            state       <= ST_W_MEPC;
            cause_q     <= ev_cause;
            tval_q      <= ev_tval;
            csr_wr_en   <= 1'b1;
            csr_wr_addr <= CSR_ADDR_MEPC;
            csr_wr_data <= ev_epc & ~32'h3;
          end else if (take_mret) begin
            state       <= ST_R_MSTATUS;
            csr_wr_en   <= 1'b1;
            csr_wr_addr <= CSR_ADDR_MSTATUS;
            csr_wr_data <= mret_mstatus(mstatus);
          end
        end
        ST_W_MEPC: begin
          state       <= ST_W_MCAUSE;
          csr_wr_en   <= 1'b1;
          csr_wr_addr <= CSR_ADDR_MCAUSE;
          csr_wr_data <= cause_q;
        end
        ST_W_MCAUSE: begin
          state       <= ST_W_MTVAL;
          csr_wr_en   <= 1'b1;
          csr_wr_addr <= CSR_ADDR_MTVAL;
          csr_wr_data <= tval_q;
        end
        ST_W_MTVAL: begin
          state       <= ST_W_MSTATUS;
          csr_wr_en   <= 1'b1;
          csr_wr_addr <= CSR_ADDR_MSTATUS;
          csr_wr_data <= trap_mstatus(mstatus);
        end
        ST_W_MSTATUS: begin
          state          <= ST_REDIRECT;
          redirect_valid <= 1'b1;
          redirect_pc    <= trap_target;
        end
        ST_R_MSTATUS: begin
          state          <= ST_REDIRECT;
          redirect_valid <= 1'b1;
          redirect_pc    <= mepc & ~32'h3;
        end
        ST_REDIRECT: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: table-driven cause/stall checks plus
// hand-written interrupt, MRET, reset-abort and vectored sequences.
module tb_trap_ctrl;
  import trap_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset, stall, except_en, mret_en;
  logic [3:0]  except_op;
  logic [31:0] except_pc, except_tval, next_pc;
  logic        irq_ext, irq_sw, irq_timer;
  logic [31:0] mstatus, mie, mtvec, mepc;
  logic        csr_wr_en, flush, busy, redirect_valid;
  logic [11:0] csr_wr_addr;
  logic [31:0] csr_wr_data, redirect_pc;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  trap_ctrl #(.RESET_VECTOR(32'h0000_1000)) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .except_en      (except_en),
    .except_op      (except_op),
    .except_pc      (except_pc),
    .except_tval    (except_tval),
    .mret_en        (mret_en),
    .next_pc        (next_pc),
    .irq_ext        (irq_ext),
    .irq_sw         (irq_sw),
    .irq_timer      (irq_timer),
    .mstatus        (mstatus),
    .mie            (mie),
    .mtvec          (mtvec),
    .mepc           (mepc),
    .csr_wr_en      (csr_wr_en),
    .csr_wr_addr    (csr_wr_addr),
    .csr_wr_data    (csr_wr_data),
    .flush          (flush),
    .busy           (busy),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  typedef struct {
    logic        stall;
    logic        fl;
    logic        wr;
    logic [11:0] addr;
    logic [31:0] data;
    logic        rv;
    logic [31:0] rpc;
    logic        bsy;
  } row_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] pc;
    logic [31:0] tvec;
    logic [31:0] cause;
    logic [31:0] epc;
    logic [31:0] rpc;
  } op_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input string nm, input logic [11:0] a, input logic [31:0] d);
    chk1({nm, ".wr_en"}, csr_wr_en, 1'b1);
    chk({nm, ".addr"}, {20'b0, csr_wr_addr}, {20'b0, a});
    chk({nm, ".data"}, csr_wr_data, d);
    chk1({nm, ".busy"}, busy, 1'b1);
    chk1({nm, ".flush"}, flush, 1'b0);
  endtask

  // Called in the acceptance cycle with the request already driven.
  // The CSR file update of mstatus is modelled by driving e_mst after its write.
  task automatic trap_seq(input string nm, input logic [31:0] e_epc, input logic [31:0] e_cause,
                          input logic [31:0] e_tval, input logic [31:0] e_mst, input logic [31:0] e_rpc);
    #1;
    chk1({nm, ".accept_flush"}, flush, 1'b1);
    chk1({nm, ".accept_busy"}, busy, 1'b0);
    step();
    except_en = 1'b0;
    mret_en   = 1'b0;
    expect_wr({nm, ".mepc"}, CSR_ADDR_MEPC, e_epc);
    step();
    expect_wr({nm, ".mcause"}, CSR_ADDR_MCAUSE, e_cause);
    step();
    expect_wr({nm, ".mtval"}, CSR_ADDR_MTVAL, e_tval);
    step();
    expect_wr({nm, ".mstatus"}, CSR_ADDR_MSTATUS, e_mst);
    mstatus = e_mst;
    step();
    chk1({nm, ".redir_valid"}, redirect_valid, 1'b1);
    chk({nm, ".redir_pc"}, redirect_pc, e_rpc);
    chk1({nm, ".redir_wr_en"}, csr_wr_en, 1'b0);
    step();
    chk1({nm, ".idle_busy"}, busy, 1'b0);
    chk1({nm, ".idle_redir"}, redirect_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    op_t  ops [4];
    row_t rows [10];
    logic [31:0] vec_rpc;

    reset = 1'b1; stall = 1'b0; except_en = 1'b1; mret_en = 1'b0;
    except_op = C_EXCEPTOP_ECALL; except_pc = '0; except_tval = '0; next_pc = '0;
    irq_ext = 1'b0; irq_sw = 1'b0; irq_timer = 1'b0;
    mstatus = 32'h8; mie = '0; mtvec = 32'h200; mepc = '0;

    // Reset state, with a request present that must be ignored
    step();
    step();
    chk1("reset.busy", busy, 1'b0);
    chk1("reset.wr_en", csr_wr_en, 1'b0);
    chk1("reset.flush", flush, 1'b0);
    chk1("reset.redir", redirect_valid, 1'b0);
    chk("reset.data", csr_wr_data, 32'h0);
    chk("reset.rpc", redirect_pc, 32'h0);
    except_en = 1'b0;
    reset = 1'b0;
    step();

    // Cause encoding, mepc alignment, direct-mode target and mtvec==0 fallback
    ops[0] = '{C_EXCEPTOP_ECALL,   32'h100, 32'h200, 32'd11, 32'h100, 32'h200};
    ops[1] = '{C_EXCEPTOP_EBREAK,  32'h102, 32'h203, 32'd3,  32'h100, 32'h200};
    ops[2] = '{C_EXCEPTOP_ILLEGAL, 32'h207, 32'h0,   32'd2,  32'h204, 32'h1000};
    ops[3] = '{4'hF,               32'h300, 32'h201, 32'd0,  32'h300, 32'h200};
    for (int i = 0; i < 4; i++) begin
      except_en   = 1'b1;
      except_op   = ops[i].op;
      except_pc   = ops[i].pc;
      except_tval = 32'hA000_0000 + 32'(i);
      mtvec       = ops[i].tvec;
      mstatus     = 32'h8;
      trap_seq($sformatf("op%0d", i), ops[i].epc, ops[i].cause, 32'hA000_0000 + 32'(i),
               32'h1880, ops[i].rpc);
    end
    mtvec = 32'h200;

    // Interrupts pending but globally masked: nothing happens
    mstatus = 32'h0; mie = 32'h880; irq_ext = 1'b1; irq_timer = 1'b1; next_pc = 32'h302;
    #1;
    chk1("masked.flush", flush, 1'b0);
    step();
    chk1("masked.busy", busy, 1'b0);
    chk1("masked.wr_en", csr_wr_en, 1'b0);
    mstatus = 32'h8;
    trap_seq("irq_ext", 32'h300, 32'h8000_000B, 32'h0, 32'h1880, 32'h200);
    irq_ext = 1'b0; irq_timer = 1'b0;

    // Exception beats a simultaneous interrupt
    mstatus = 32'h8; mie = 32'h800; irq_ext = 1'b1;
    except_en = 1'b1; except_op = C_EXCEPTOP_EBREAK; except_pc = 32'h100; except_tval = 32'h0010_0073;
    trap_seq("ebreak_vs_irq", 32'h100, 32'd3, 32'h0010_0073, 32'h1880, 32'h200);
    chk1("ebreak_vs_irq.no_retake", flush, 1'b0);

    // MRET restores MIE; the still-pending interrupt is taken right after
    mret_en = 1'b1; mepc = 32'h104; next_pc = 32'h108;
    #1;
    chk1("mret.flush", flush, 1'b1);
    step();
    mret_en = 1'b0;
    expect_wr("mret.mstatus", CSR_ADDR_MSTATUS, 32'h1888);
    mstatus = 32'h1888;
    step();
    chk1("mret.redir_valid", redirect_valid, 1'b1);
    chk("mret.redir_pc", redirect_pc, 32'h104);
    step();
    trap_seq("irq_after_mret", 32'h108, 32'h8000_000B, 32'h0, 32'h1880, 32'h200);
    irq_ext = 1'b0; mie = '0;

    // Stall held three cycles in W_MCAUSE
    rows[0] = '{1'b0, 1'b1, 1'b0, 12'h000, 32'h0,    1'b0, 32'h0,   1'b0};
    rows[1] = '{1'b0, 1'b0, 1'b1, 12'h341, 32'h100,  1'b0, 32'h0,   1'b1};
    rows[2] = '{1'b1, 1'b0, 1'b1, 12'h342, 32'd11,   1'b0, 32'h0,   1'b1};
    rows[3] = '{1'b1, 1'b0, 1'b1, 12'h342, 32'd11,   1'b0, 32'h0,   1'b1};
    rows[4] = '{1'b1, 1'b0, 1'b1, 12'h342, 32'd11,   1'b0, 32'h0,   1'b1};
    rows[5] = '{1'b0, 1'b0, 1'b1, 12'h342, 32'd11,   1'b0, 32'h0,   1'b1};
    rows[6] = '{1'b0, 1'b0, 1'b1, 12'h343, 32'h55,   1'b0, 32'h0,   1'b1};
    rows[7] = '{1'b0, 1'b0, 1'b1, 12'h300, 32'h1880, 1'b0, 32'h0,   1'b1};
    rows[8] = '{1'b0, 1'b0, 1'b0, 12'h000, 32'h0,    1'b1, 32'h200, 1'b1};
    rows[9] = '{1'b0, 1'b0, 1'b0, 12'h000, 32'h0,    1'b0, 32'h0,   1'b0};
    mstatus = 32'h8;
    except_en = 1'b1; except_op = C_EXCEPTOP_ECALL; except_pc = 32'h100; except_tval = 32'h55;
    for (int i = 0; i < 10; i++) begin
      stall = rows[i].stall;
      #1;
      chk1($sformatf("stall[%0d].flush", i), flush, rows[i].fl);
      chk1($sformatf("stall[%0d].wr_en", i), csr_wr_en, rows[i].wr);
      chk($sformatf("stall[%0d].addr", i), {20'b0, csr_wr_addr}, {20'b0, rows[i].addr});
      chk($sformatf("stall[%0d].data", i), csr_wr_data, rows[i].data);
      chk1($sformatf("stall[%0d].redir", i), redirect_valid, rows[i].rv);
      chk($sformatf("stall[%0d].rpc", i), redirect_pc, rows[i].rpc);
      chk1($sformatf("stall[%0d].busy", i), busy, rows[i].bsy);
      step();
      if (i == 0) except_en = 1'b0;
    end
    stall = 1'b0;

    // Reset in W_MTVAL aborts the sequence with no redirect
    mstatus = 32'h8;
    except_en = 1'b1; except_op = C_EXCEPTOP_ECALL; except_pc = 32'h100; except_tval = 32'h0;
    #1;
    chk1("rst_mid.flush", flush, 1'b1);
    step();
    except_en = 1'b0;
    step();
    step();
    chk("rst_mid.in_mtval", {20'b0, csr_wr_addr}, {20'b0, CSR_ADDR_MTVAL});
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk1("rst_mid.busy", busy, 1'b0);
    chk1("rst_mid.wr_en", csr_wr_en, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk1($sformatf("rst_mid.redir[%0d]", i), redirect_valid, 1'b0);
      chk1($sformatf("rst_mid.busy[%0d]", i), busy, 1'b0);
      step();
    end

    // Timer interrupt with mtvec mode bits 01
`ifdef TRAP_CTRL_VECTORED_EN
    vec_rpc = 32'h21C;
`else
    vec_rpc = 32'h200;
`endif
    mtvec = 32'h201; mie = 32'h80; irq_timer = 1'b1; mstatus = 32'h8; next_pc = 32'h500;
    trap_seq("timer_vec", 32'h500, 32'h8000_0007, 32'h0, 32'h1880, vec_rpc);
    irq_timer = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
